// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl -- single-outstanding load/store initiator
//
// Sits between the execute stage and a data memory port. It accepts one
// memory instruction over a valid/ready handshake and drives a word-aligned
// memory request with lane-shifted write data and byte strobes. It then waits
// for mem_ack, aligns and extends the load data, and returns the result over
// a second valid/ready handshake. It never holds more than one transaction.
//
// Parameters
//   TIMEOUT   maximum cycles spent in REQ without mem_ack before the access
//             is aborted with out_err (>= 1)
//
// Optional feature macro
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned H/HU/SH/W/SW accesses and
//                         undefined load funct3 encodings complete at once
//                         with out_err=1 and do not touch memory. When it is
//                         undefined, misaligned halfword accesses are forced
//                         onto their natural lane, words use lane 0, and
//                         out_err reports only timeouts.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   in_valid/in_ready                 request handshake
//   in_is_store, in_funct3, in_addr,
//   in_wdata, in_rd                   request fields
//   out_valid/out_ready               response handshake
//   out_rdata, out_rd, out_wen,
//   out_err                           response fields
//   mem_en, mem_wr, mem_addr,
//   mem_wdata, mem_wstrb              memory request (held during REQ)
//   mem_rdata, mem_ack                memory response
// ---------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [4:0]  out_rd,
    output logic        out_wen,
    output logic        out_err,

    output logic        mem_en,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Access size derived from funct3[1:0]; 11 collapses onto word so the
    // undefined encodings 011/110/111 all behave as W.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Latched request fields needed after the request phase
    logic               is_store_q, is_store_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [1:0]         off_q, off_d;
    logic [4:0]         rd_q, rd_d;

    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_rdata_q, out_rdata_d;
    logic [4:0]         out_rd_q, out_rd_d;
    logic               out_wen_q, out_wen_d;
    logic               out_err_q, out_err_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_wr_q, mem_wr_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [3:0]         mem_wstrb_q, mem_wstrb_d;

    // ------------------------------------------------------------------
    // Request decode (combinational on the incoming fields)
    // ------------------------------------------------------------------
    logic [1:0]  req_size;
    logic [1:0]  req_off;
    logic [3:0]  req_strb;
    logic [31:0] req_wdata;
    logic        req_misaligned;
    logic        req_f3_undef;
    logic        accept;

    always_comb begin
        case (in_funct3[1:0])
            2'b00:   req_size = SZ_B;
            2'b01:   req_size = SZ_H;
            default: req_size = SZ_W;
        endcase

        // Effective lane offset. Halfwords snap to their natural lane and
        // words to lane 0; for aligned accesses this equals addr[1:0].
        case (req_size)
            SZ_B:    req_off = in_addr[1:0];
            SZ_H:    req_off = {in_addr[1], 1'b0};
            default: req_off = 2'b00;
        endcase

        req_strb = 4'b0000;
        if (in_is_store) begin
            case (req_size)
                SZ_B:    req_strb = 4'b0001 << req_off;
                SZ_H:    req_strb = 4'b0011 << req_off;
                default: req_strb = 4'b1111;
            endcase
        end

        req_wdata = in_wdata << {req_off, 3'b000};

        req_f3_undef = (in_funct3 == 3'b011) || (in_funct3 == 3'b110) ||
                       (in_funct3 == 3'b111);

`ifdef LSU_MISALIGN_TRAP_EN
        req_misaligned = ((req_size == SZ_H) && in_addr[0]) ||
                         ((req_size == SZ_W) && (in_addr[1:0] != 2'b00)) ||
                         (!in_is_store && req_f3_undef);
`else
        req_misaligned = 1'b0;
`endif
    end

    // in_ready_q is only high in IDLE, and stays low for the first cycle
    // after reset, so requests presented then are not taken.
    assign accept = in_valid && in_ready_q;

    // Align the addressed lane to bit 0, then sign/zero extend.
    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [31:0] shifted;
        shifted = word >> {off, 3'b000};
        case (size)
            SZ_B:    load_extend = uns ? {24'b0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    load_extend = uns ? {16'b0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
            default: load_extend = shifted;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_store_d  = is_store_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        rd_d        = rd_q;
        out_valid_d = out_valid_q;
        out_rdata_d = out_rdata_q;
        out_rd_d    = out_rd_q;
        out_wen_d   = out_wen_q;
        out_err_d   = out_err_q;
        mem_en_d    = mem_en_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    is_store_d = in_is_store;
                    size_d     = req_size;
                    uns_d      = in_funct3[2];
                    off_d      = req_off;
                    rd_d       = in_rd;
                    cnt_d      = '0;
                    if (req_misaligned) begin
                        // Trapped access: straight to the response, no memory cycle
                        state_d     = ST_RESP;
                        out_valid_d = 1'b1;
                        out_rdata_d = 32'h0;
                        out_rd_d    = in_rd;
                        out_wen_d   = 1'b0;
                        out_err_d   = 1'b1;
                    end else begin
                        state_d     = ST_REQ;
                        mem_en_d    = 1'b1;
                        mem_wr_d    = in_is_store;
                        mem_addr_d  = {in_addr[31:2], 2'b00};
                        mem_wdata_d = in_is_store ? req_wdata : 32'h0;
                        mem_wstrb_d = req_strb;
                    end
                end
            end

            ST_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                // mem_ack takes priority over the timeout in the final cycle
                if (mem_ack || (cnt_q == CNT_LAST)) begin
                    state_d     = ST_RESP;
                    mem_en_d    = 1'b0;
                    mem_wr_d    = 1'b0;
                    mem_addr_d  = 32'h0;
                    mem_wdata_d = 32'h0;
                    mem_wstrb_d = 4'b0000;
                    out_valid_d = 1'b1;
                    out_rd_d    = rd_q;
                    if (mem_ack) begin
                        out_err_d   = 1'b0;
                        out_wen_d   = !is_store_q;
                        out_rdata_d = is_store_q ? 32'h0
                                    : load_extend(mem_rdata, off_q, size_q, uns_q);
                    end else begin
                        out_err_d   = 1'b1;
                        out_wen_d   = 1'b0;
                        out_rdata_d = 32'h0;
                    end
                end
            end

            ST_RESP: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    out_rdata_d = 32'h0;
                    out_rd_d    = 5'd0;
                    out_wen_d   = 1'b0;
                    out_err_d   = 1'b0;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                mem_en_d    = 1'b0;
            end
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    // ------------------------------------------------------------------
    // State register; reset drops any access in flight
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            is_store_q  <= 1'b0;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            rd_q        <= 5'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_rdata_q <= 32'h0;
            out_rd_q    <= 5'd0;
            out_wen_q   <= 1'b0;
            out_err_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'b0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_store_q  <= is_store_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_rdata_q <= out_rdata_d;
            out_rd_q    <= out_rd_d;
            out_wen_q   <= out_wen_d;
            out_err_q   <= out_err_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_rdata = out_rdata_q;
    assign out_rd    = out_rd_q;
    assign out_wen   = out_wen_q;
    assign out_err   = out_err_q;
    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl -- directed, self-checking bench for lsu_ctrl (TIMEOUT=4).
// Expected responses are queued when a request is issued and popped when
// the response handshake is observed.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_err;
    logic        mem_en;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    lsu_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_is_store(in_is_store),
        .in_funct3  (in_funct3),
        .in_addr    (in_addr),
        .in_wdata   (in_wdata),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rdata  (out_rdata),
        .out_rd     (out_rd),
        .out_wen    (out_wen),
        .out_err    (out_err),
        .mem_en     (mem_en),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        wen;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] rdata, input logic [4:0] rd, input logic wen, input logic err);
        resp_t r;
        r.rdata = rdata;
        r.rd    = rd;
        r.wen   = wen;
        r.err   = err;
        exp_q.push_back(r);
    endtask

    // Present a request and return one cycle after the accepting edge.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        in_is_store = st;
        in_funct3   = f3;
        in_addr     = addr;
        in_wdata    = wdata;
        in_rd       = rd;
        in_valid    = 1'b1;
        for (int i = 0; i < 20 && !in_ready; i++) tick();
        check("issue_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a response, compare it with the scoreboard head.
    task automatic collect(input string tag);
        resp_t e;
        int    w;
        w = 0;
        while (!out_valid && w < 20) begin
            tick();
            w++;
        end
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_sb_depth"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_rdata"}, out_rdata, e.rdata);
            check({tag, "_rd"}, out_rd, e.rd);
            check({tag, "_wen"}, out_wen, e.wen);
            check({tag, "_err"}, out_err, e.err);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 1'b0);
    endtask

    // Aligned access with an immediate acknowledge: checks the memory side
    // at N+1, the result at N+2, and the result contents.
    task automatic do_access(input string tag, input logic st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input logic [4:0] rd,
                             input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                             input logic [31:0] exp_rdata);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        issue(st, f3, addr, wdata, rd);
        push(st ? 32'h0 : exp_rdata, rd, !st, 1'b0);
        check({tag, "_mem_en"}, mem_en, 1'b1);
        check({tag, "_mem_wr"}, mem_wr, st);
        check({tag, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        check({tag, "_mem_wstrb"}, mem_wstrb, exp_strb);
        if (st) check({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
        check({tag, "_early_valid"}, out_valid, 1'b0);
        tick();
        check({tag, "_valid_n2"}, out_valid, 1'b1);
        check({tag, "_mem_en_off"}, mem_en, 1'b0);
        collect(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic seen;

        rst         = 1'b1;
        in_valid    = 1'b0;
        in_is_store = 1'b0;
        in_funct3   = 3'b000;
        in_addr     = 32'h0;
        in_wdata    = 32'h0;
        in_rd       = 5'd0;
        out_ready   = 1'b0;
        mem_rdata   = 32'h0;
        mem_ack     = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_rdata", out_rdata, 32'h0);
        check("rst_mem_wstrb", mem_wstrb, 4'b0000);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1'b1);

        // LB sign extension from lane 3
        do_access("lb_off3", 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80AA_BBCC, 5'd1,
                  4'b0000, 32'h0, 32'hFFFF_FF80);
        // SH to upper halfword
        do_access("sh_off2", 1'b1, 3'b001, 32'h8000_0102, 32'h1234_ABCD, 32'h0, 5'd2,
                  4'b1100, 32'hABCD_0000, 32'h0);
        // Further lane/extension patterns
        do_access("lbu_off1", 1'b0, 3'b100, 32'h0000_0101, 32'h0, 32'h80AA_BBCC, 5'd3,
                  4'b0000, 32'h0, 32'h0000_00BB);
        do_access("lh_off2", 1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_0000, 5'd4,
                  4'b0000, 32'h0, 32'hFFFF_8001);
        do_access("lb_pos", 1'b0, 3'b000, 32'h0000_0000, 32'h0, 32'h0000_007F, 5'd6,
                  4'b0000, 32'h0, 32'h0000_007F);
        do_access("sb_off1", 1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 32'h0, 5'd8,
                  4'b0010, 32'h0000_A500, 32'h0);
        do_access("sw", 1'b1, 3'b010, 32'h0000_0004, 32'hCAFE_F00D, 32'h0, 5'd10,
                  4'b1111, 32'hCAFE_F00D, 32'h0);
        do_access("lw", 1'b0, 3'b010, 32'h0000_0008, 32'h0, 32'h1234_5678, 5'd12,
                  4'b0000, 32'h0, 32'h1234_5678);

        // LHU with out_ready held low for 5 cycles
        mem_ack   = 1'b1;
        mem_rdata = 32'hF00D_1234;
        issue(1'b0, 3'b101, 32'h8000_0002, 32'h0, 5'd7);
        push(32'h0000_F00D, 5'd7, 1'b1, 1'b0);
        tick();
        mem_rdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            check("lhu_hold_valid", out_valid, 1'b1);
            check("lhu_hold_rdata", out_rdata, 32'h0000_F00D);
            check("lhu_hold_in_ready", in_ready, 1'b0);
            tick();
        end
        collect("lhu_hold");

        // Misaligned LW
`ifdef LSU_MISALIGN_TRAP_EN
        mem_ack = 1'b1;
        issue(1'b0, 3'b010, 32'h8000_0001, 32'h0, 5'd5);
        push(32'h0, 5'd5, 1'b0, 1'b1);
        check("lw_mis_valid_n1", out_valid, 1'b1);
        check("lw_mis_err_n1", out_err, 1'b1);
        check("lw_mis_mem_en", mem_en, 1'b0);
        collect("lw_mis");
`else
        do_access("lw_mis", 1'b0, 3'b010, 32'h8000_0001, 32'h0, 32'hDEAD_BEEF, 5'd5,
                  4'b0000, 32'h0, 32'hDEAD_BEEF);
`endif

        // Timeout with a late acknowledge
        mem_ack = 1'b0;
        issue(1'b0, 3'b010, 32'h8000_0010, 32'h0, 5'd9);
        push(32'h0, 5'd9, 1'b0, 1'b1);
        n = 0;
        while (mem_en && n < 20) begin
            n++;
            tick();
        end
        check("to_mem_en_cycles", n, TO);
        check("to_valid", out_valid, 1'b1);
        check("to_err", out_err, 1'b1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        check("to_late_ack_rdata", out_rdata, 32'h0);
        check("to_late_ack_err", out_err, 1'b1);
        collect("timeout");
        mem_ack = 1'b0;
        tick();

        // Reset during REQ drops the access
        issue(1'b0, 3'b010, 32'h8000_0020, 32'h0, 5'd11);
        check("rst_req_mem_en", mem_en, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_mem_en", mem_en, 1'b0);
        check("rst_mid_out_valid", out_valid, 1'b0);
        rst = 1'b0;
        tick();
        check("rst_mid_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        mem_ack   = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen = seen | out_valid | mem_en;
            tick();
        end
        check("rst_mid_no_resp", seen, 1'b0);
        out_ready = 1'b0;

        // Recovery after the dropped access
        do_access("recover_lw", 1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'hA5A5_5A5A, 5'd13,
                  4'b0000, 32'h0, 32'hA5A5_5A5A);

        check("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
